// File: rtl/decimator_prog.sv
// Run-time programmable sample-and-hold decimator: keeps one of every ratio_m1+1
// valid samples at a selectable phase, with a valid/ready output and sticky overrun.
module decimator_prog #(
    parameter int          DATA_W       = 27,
    parameter int          CNT_W        = 9,
    parameter int unsigned DEF_RATIO_M1 = 511,
    parameter int unsigned DEF_PHASE    = 511
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [CNT_W-1:0]  ratio_m1,
    input  logic [CNT_W-1:0]  phase,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              new_data,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam logic [CNT_W-1:0] DEF_RATIO_C = CNT_W'(DEF_RATIO_M1);
    localparam logic [CNT_W-1:0] DEF_PHASE_C =
        CNT_W'((DEF_PHASE < DEF_RATIO_M1) ? DEF_PHASE : DEF_RATIO_M1);

    // A phase beyond the frame length would never be reached, so it is pinned to the last index.
    function automatic logic [CNT_W-1:0] clamp_phase(input logic [CNT_W-1:0] p,
                                                     input logic [CNT_W-1:0] r);
        logic [CNT_W-1:0] res;
        if (p > r) begin
            res = r;
        end else begin
            res = p;
        end
        return res;
    endfunction

    logic [CNT_W-1:0]  cnt_r,       cnt_s;
    logic [CNT_W-1:0]  ratio_act_r, ratio_act_s;
    logic [CNT_W-1:0]  phase_act_r, phase_act_s;
    logic [DATA_W-1:0] data_out_r,  data_out_s;
    logic              out_valid_r, out_valid_s;
    logic              new_data_r,  new_data_s;
    logic              overrun_r,   overrun_s;
    logic              frame_end_s;
    logic              capture_s;
    logic              ovr_event_s;

    // Frame bookkeeping, capture, handshake and overrun next-state.
    always_comb begin
        cnt_s       = cnt_r;
        ratio_act_s = ratio_act_r;
        phase_act_s = phase_act_r;
        data_out_s  = data_out_r;
        out_valid_s = out_valid_r;
        new_data_s  = 1'b0;
        overrun_s   = overrun_r;
        frame_end_s = in_valid && (cnt_r == ratio_act_r);
        capture_s   = in_valid && (cnt_r == phase_act_r);
        ovr_event_s = capture_s && out_valid_r && !out_ready;

        if (clear) begin
            // Restart dominates everything except the held sample and the sticky flag.
            cnt_s       = {CNT_W{1'b0}};
            ratio_act_s = ratio_m1;
            phase_act_s = clamp_phase(phase, ratio_m1);
            out_valid_s = 1'b0;
            new_data_s  = 1'b0;
        end else begin
            if (in_valid) begin
                if (frame_end_s) begin
                    cnt_s = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_s = cnt_r;
            end

            if (frame_end_s) begin
                ratio_act_s = ratio_m1;
                phase_act_s = clamp_phase(phase, ratio_m1);
            end else begin
                ratio_act_s = ratio_act_r;
                phase_act_s = phase_act_r;
            end

            if (capture_s) begin
                data_out_s  = data_in;
                out_valid_s = 1'b1;
                new_data_s  = 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_s = 1'b0;
            end else begin
                out_valid_s = out_valid_r;
            end

            if (ovr_event_s) begin
                overrun_s = 1'b1;
            end else if (ovr_clr) begin
                overrun_s = 1'b0;
            end else begin
                overrun_s = overrun_r;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            ratio_act_r <= DEF_RATIO_C;
            phase_act_r <= DEF_PHASE_C;
            data_out_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            new_data_r  <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            cnt_r       <= cnt_s;
            ratio_act_r <= ratio_act_s;
            phase_act_r <= phase_act_s;
            data_out_r  <= data_out_s;
            out_valid_r <= out_valid_s;
            new_data_r  <= new_data_s;
            overrun_r   <= overrun_s;
        end
    end

    assign data_out  = data_out_r;
    assign out_valid = out_valid_r;
    assign new_data  = new_data_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_decimator_prog.sv
// Directed self-checking bench for decimator_prog.
module tb_decimator_prog;

    localparam int DATA_W = 27;
    localparam int CNT_W  = 9;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic [CNT_W-1:0]  ratio_m1;
    logic [CNT_W-1:0]  phase;
    logic              in_valid;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              new_data;
    logic              overrun;
    logic              ovr_clr;

    int n_checks = 0;
    int n_errors = 0;

    decimator_prog #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .DEF_RATIO_M1(511), .DEF_PHASE(511)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .ratio_m1(ratio_m1), .phase(phase),
        .in_valid(in_valid), .data_in(data_in), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .new_data(new_data),
        .overrun(overrun), .ovr_clr(ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; ratio_m1 = 9'd511; phase = 9'd511;
        in_valid = 1'b0; data_in = '0; out_ready = 1'b0; ovr_clr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic program_and_clear(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] p);
        ratio_m1 = r; phase = p; clear = 1'b1; in_valid = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({out_valid, new_data, overrun} !== 3'b000 || data_out !== 27'd0) begin
            n_errors++;
            $display("FAIL reset_state: valid=%0b new=%0b ovr=%0b data=%0d, required 0 0 0 0",
                     out_valid, new_data, overrun, data_out);
        end
    endtask

    task automatic test_default_ratio();
        bit cap;
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 1540; k++) begin
            data_in = DATA_W'(k);
            tick();
            cap = (k == 511) || (k == 1023) || (k == 1535);
            n_checks++;
            if (new_data !== cap || out_valid !== cap) begin
                n_errors++;
                $display("FAIL default_timing k=%0d: new=%0b valid=%0b, required %0b",
                         k, new_data, out_valid, cap);
            end
            if (cap) begin
                n_checks++;
                if (data_out !== DATA_W'(k)) begin
                    n_errors++;
                    $display("FAIL default_data k=%0d: got %0d, required %0d", k, data_out, k);
                end
            end
        end
    endtask

    task automatic test_valid_gating();
        int n;
        bit cap;
        do_reset();
        out_ready = 1'b1;
        program_and_clear(9'd3, 9'd1);
        n = 0;
        for (int c = 0; c < 24; c++) begin
            in_valid = (c % 2 == 0);
            data_in  = in_valid ? DATA_W'(n) : 27'h5A5A5A5;
            tick();
            cap = in_valid && (n == 1 || n == 5 || n == 9);
            n_checks++;
            if (new_data !== cap) begin
                n_errors++;
                $display("FAIL gating_new c=%0d n=%0d: got %0b, required %0b", c, n, new_data, cap);
            end
            if (cap) begin
                n_checks++;
                if (data_out !== DATA_W'(n)) begin
                    n_errors++;
                    $display("FAIL gating_data n=%0d: got %0d, required %0d", n, data_out, n);
                end
            end
            if (in_valid) n++;
        end
    endtask

    task automatic test_ratio_change();
        bit cap;
        do_reset();
        out_ready = 1'b1;
        program_and_clear(9'd7, 9'd7);
        in_valid = 1'b1;
        for (int n = 0; n < 14; n++) begin
            if (n == 3) begin
                ratio_m1 = 9'd1; phase = 9'd1;
            end
            data_in = DATA_W'(n + 100);
            tick();
            cap = (n == 7) || (n == 9) || (n == 11) || (n == 13);
            n_checks++;
            if (new_data !== cap) begin
                n_errors++;
                $display("FAIL ratio_change_new n=%0d: got %0b, required %0b", n, new_data, cap);
            end
            if (cap) begin
                n_checks++;
                if (data_out !== DATA_W'(n + 100)) begin
                    n_errors++;
                    $display("FAIL ratio_change_data n=%0d: got %0d, required %0d",
                             n, data_out, n + 100);
                end
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        program_and_clear(9'd1, 9'd1);
        out_ready = 1'b0; in_valid = 1'b1;
        for (int n = 0; n < 6; n++) begin
            data_in = DATA_W'(n + 40);
            tick();
            if (n >= 1) begin
                n_checks++;
                if (out_valid !== 1'b1 || overrun !== (n >= 3)) begin
                    n_errors++;
                    $display("FAIL overrun_seq n=%0d: valid=%0b ovr=%0b, required 1 %0b",
                             n, out_valid, overrun, (n >= 3));
                end
            end
        end
        n_checks++;
        if (data_out !== 27'd45) begin
            n_errors++;
            $display("FAIL overrun_newest: got %0d, required 45", data_out);
        end
        in_valid = 1'b0; ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL ovr_clr: ovr=%0b valid=%0b, required 0 1", overrun, out_valid);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL consume: valid=%0b, required 0", out_valid);
        end
        in_valid = 1'b1;
        for (int n = 6; n < 10; n++) begin
            data_in = DATA_W'(n + 40);
            ovr_clr = (n == 9);
            tick();
        end
        ovr_clr = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (overrun !== 1'b1 || data_out !== 27'd49) begin
            n_errors++;
            $display("FAIL ovr_set_wins: ovr=%0b data=%0d, required 1 49", overrun, data_out);
        end
    endtask

    task automatic test_passthrough();
        logic [DATA_W-1:0] exp;
        do_reset();
        out_ready = 1'b1;
        program_and_clear(9'd0, 9'd5);
        in_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            exp = DATA_W'(n * 3 + 7);
            data_in = exp;
            tick();
            n_checks++;
            if (data_out !== exp || {out_valid, new_data, overrun} !== 3'b110) begin
                n_errors++;
                $display("FAIL passthrough n=%0d: data=%0d v/n/o=%0b%0b%0b, required %0d 110",
                         n, data_out, out_valid, new_data, overrun, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 712; k++) begin
            data_in = DATA_W'(k + 5);
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b1 || data_out !== 27'd516) begin
            n_errors++;
            $display("FAIL pre_reset: valid=%0b data=%0d, required 1 516", out_valid, data_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, new_data, overrun} !== 3'b000 || data_out !== 27'd0) begin
            n_errors++;
            $display("FAIL async_reset: valid=%0b new=%0b ovr=%0b data=%0d, required 0 0 0 0",
                     out_valid, new_data, overrun, data_out);
        end
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 512; k++) begin
            data_in = DATA_W'(k + 2000);
            tick();
            n_checks++;
            if (new_data !== (k == 511)) begin
                n_errors++;
                $display("FAIL post_reset_new k=%0d: got %0b, required %0b", k, new_data, (k == 511));
            end
        end
        n_checks++;
        if (data_out !== 27'd2511) begin
            n_errors++;
            $display("FAIL post_reset_data: got %0d, required 2511", data_out);
        end
    endtask

    task automatic test_clear_mid();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 612; k++) begin
            data_in = DATA_W'(k + 3000);
            tick();
        end
        clear = 1'b1;
        data_in = 27'd9999;
        tick();
        clear = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || new_data !== 1'b0 || data_out !== 27'd3511) begin
            n_errors++;
            $display("FAIL clear: valid=%0b new=%0b data=%0d, required 0 0 3511",
                     out_valid, new_data, data_out);
        end
        for (int j = 0; j < 512; j++) begin
            data_in = DATA_W'(j + 4000);
            tick();
            n_checks++;
            if (new_data !== (j == 511)) begin
                n_errors++;
                $display("FAIL post_clear_new j=%0d: got %0b, required %0b", j, new_data, (j == 511));
            end
        end
        n_checks++;
        if (data_out !== 27'd4511 || overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL post_clear_data: data=%0d ovr=%0b, required 4511 0", data_out, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_default_ratio();
        test_valid_gating();
        test_ratio_change();
        test_overrun();
        test_passthrough();
        test_reset_mid();
        test_clear_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decimator_prog.md
Name: decimator_prog

Overview:
- Parametrised, run-time-programmable successor to the fixed 512:1 sample-and-hold decimator in the digital filter chain.
- Keeps one out of every R valid input samples, where R = ratio_m1+1.
- Provides:
  - a selectable sample phase within each frame;
  - an input valid qualifier;
  - an output valid/ready handshake with a sticky overrun flag.
- Sits between the CIC/integrator stage and the downstream FIR/serialiser.

Parameters:
DATA_W, 27, width of data_in/data_out (unsigned)
CNT_W, 9, frame counter width; maximum ratio 2^CNT_W
DEF_RATIO_M1, 511, ratio_m1 loaded into the active register at reset
DEF_PHASE, 511, phase loaded into the active register at reset

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous frame restart
ratio_m1  input  CNT_W  requested decimation ratio minus 1
phase  input  CNT_W  requested capture index within frame (0..ratio)
in_valid  input  1  data_in qualifier; counter advances only when high
data_in  input  DATA_W  input sample, unsigned
out_valid  output  1  data_out holds an unconsumed sample
out_ready  input  1  downstream accepts data_out when out_valid & out_ready
data_out  output  DATA_W  decimated sample
new_data  output  1  one-cycle pulse on each load of data_out
overrun  output  1  sticky: a sample was overwritten before being consumed
ovr_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - cnt = 0, data_out = 0, out_valid = 0, new_data = 0, overrun = 0;
  - ratio_act = DEF_RATIO_M1, phase_act = min(DEF_PHASE, DEF_RATIO_M1).
- Shadow registers ratio_act and phase_act are loaded only at frame boundaries:
  - a frame boundary is a cycle with in_valid=1 and cnt==ratio_act, or a cycle with clear=1;
  - load values: ratio_act <= ratio_m1, phase_act <= min(phase, ratio_m1);
  - mid-frame changes to ratio_m1/phase have no effect until the next boundary.
- Counter:
  - on in_valid=1: cnt <= (cnt==ratio_act) ? 0 : cnt+1;
  - on in_valid=0: cnt holds.
- Capture: in_valid=1 and cnt==phase_act loads data_out <= data_in at that edge.
  - new_data=1 for exactly the following cycle.
  - out_valid=1 from the following cycle.
  - Latency is 1 clk from the capturing edge.
- Handshake:
  - out_valid clears on the edge where out_valid & out_ready, unless a capture occurs on the same edge.
  - On simultaneous consume and capture: the new sample loads, out_valid stays 1, overrun is not set.
- Overrun:
  - A capture while out_valid=1 and out_ready=0 overwrites data_out with the newest sample, keeps out_valid=1, and sets overrun.
  - ovr_clr clears overrun.
  - ovr_clr in the same cycle as a new overrun event: set wins.
- ratio_m1=0 (R=1): every valid sample is captured (pass-through with 1-cycle latency; phase forced to 0).
- Defaults (R=512, phase 511, in_valid tied high) reproduce the legacy behaviour: one capture every 512 clocks, on the last sample of each frame.
- clear:
  - forces cnt=0, out_valid=0, new_data=0 and reloads the shadow registers;
  - data_out and overrun hold;
  - clear has priority over in_valid, capture and handshake in the same cycle.
- Reset mid-frame or mid-handshake: all state returns to reset values immediately (asynchronously); no partial sample is emitted after rst_n deasserts.
- No arithmetic on data; data_out is a bit-exact copy of data_in.

Test Plan:
- Defaults, in_valid=1 constantly, data_in = cycle index, out_ready=1:
  - required: first new_data at cycle 512 after reset release;
  - required: data_out = 511, then 1023, 1535;
  - required: out_valid high for one cycle each time.
- ratio_m1=3, phase=1, in_valid toggling 1,0,1,0..., data_in = sample number:
  - required: captured samples 1, 5, 9 (in valid-sample count);
  - required: counter frozen on invalid cycles.
- Change ratio_m1 from 7 to 1 at mid-frame (cnt=3):
  - required: current frame completes at 8 samples;
  - required: the next frames are 2 samples each.
- ratio_m1=1, out_ready=0 for 6 valid samples:
  - required: overrun=1 after the second capture;
  - required: data_out = newest captured sample;
  - required: out_valid=1 throughout;
  - required: ovr_clr -> overrun=0.
- ratio_m1=0, out_ready=1:
  - required: data_out follows data_in with 1-cycle latency;
  - required: out_valid continuous;
  - required: no overrun.
- Assert rst_n=0 asynchronously at cnt=200 with out_valid=1, and separately clear=1 at cnt=100:
  - required on reset: outputs return to reset values immediately;
  - required on clear: next capture exactly R-1-? per phase_act after restart from cnt=0, e.g. default phase yields the next new_data 512 valid samples later;
  - required on clear: data_out unchanged.
